// File: rtl/proc_scheduler.sv
// proc_scheduler: preemptive round-robin scheduler with per-slot saved PCs and slice counting.
// Define SCHED_STATS_EN to build per-slot saturating swap-in counters readable through stat_sel/stat_count.
module proc_scheduler #(
    parameter int NUM_PROCS   = 4,
    parameter int PC_W        = 10,
    parameter int QUANTUM_W   = 16,
    parameter int DEF_QUANTUM = 100,
    localparam int IDX_W      = $clog2(NUM_PROCS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 quantum_wr,
    input  logic [QUANTUM_W-1:0] quantum_in,
    input  logic [NUM_PROCS-1:0] proc_ready,
    input  logic                 retire,
    input  logic                 yield,
    input  logic [PC_W-1:0]      cur_pc,
    input  logic                 swap_ack,
    output logic                 swap_req,
    output logic                 change_proc_pc,
    output logic [PC_W-1:0]      restore_pc,
    output logic [IDX_W-1:0]     exec_proc,
    output logic                 idle,
    input  logic [IDX_W-1:0]     stat_sel,
    output logic [15:0]          stat_count
);

    typedef enum logic [2:0] {RUN, REQ, SAVE, SELECT, RESTORE, IDLE} state_t;

    localparam int PART = (2 ** PC_W) / NUM_PROCS;

    state_t               state, state_nxt;
    logic [QUANTUM_W-1:0] quantum;
    logic [QUANTUM_W-1:0] slice_cnt;
    logic [QUANTUM_W:0]   cnt_inc;
    logic                 expire;
    logic [PC_W-1:0]      pc_table [NUM_PROCS];
    logic [IDX_W-1:0]     next_idx;
    logic [IDX_W-1:0]     cand;
    logic                 next_found;

    // Compared one bit wider so a quantum shrunk below the running count still expires
    assign cnt_inc = {1'b0, slice_cnt} + {{QUANTUM_W{1'b0}}, 1'b1};
    assign expire  = retire && (cnt_inc >= {1'b0, quantum});

    // Round-robin scan starting after the running slot; the running slot is tried last
    always_comb begin
        next_idx   = exec_proc;
        next_found = 1'b0;
        cand       = '0;
        for (int unsigned k = 1; k <= NUM_PROCS; k++) begin
            cand = IDX_W'((32'(exec_proc) + k) % NUM_PROCS);
            if (!next_found && proc_ready[cand]) begin
                next_found = 1'b1;
                next_idx   = cand;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        swap_req       = 1'b0;
        change_proc_pc = 1'b0;
        idle           = 1'b0;
        unique case (state)
            RUN: begin
                if (enable && (expire || yield || !proc_ready[exec_proc]))
                    state_nxt = REQ;
            end
            REQ: begin
                swap_req = 1'b1;
                if (swap_ack)
                    state_nxt = SAVE;
            end
            SAVE:    state_nxt = SELECT;
            SELECT:  state_nxt = next_found ? RESTORE : IDLE;
            RESTORE: begin
                change_proc_pc = 1'b1;
                state_nxt      = RUN;
            end
            IDLE: begin
                idle = 1'b1;
                if (|proc_ready)
                    state_nxt = SELECT;
            end
            default: state_nxt = RUN;
        endcase
    end

    // exec_proc/restore_pc load on SELECT exit so they are already valid while change_proc_pc pulses
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= RUN;
            exec_proc  <= '0;
            slice_cnt  <= '0;
            quantum    <= QUANTUM_W'(DEF_QUANTUM);
            restore_pc <= '0;
            for (int unsigned i = 0; i < NUM_PROCS; i++)
                pc_table[i] <= PC_W'(i * PART);
        end else begin
            state <= state_nxt;
            if (quantum_wr)
                quantum <= (quantum_in == '0) ? QUANTUM_W'(1) : quantum_in;
            case (state)
                RUN: begin
                    if (enable && retire)
                        slice_cnt <= cnt_inc[QUANTUM_W-1:0];
                end
                SAVE: pc_table[exec_proc] <= cur_pc;
                SELECT: begin
                    if (next_found) begin
                        exec_proc  <= next_idx;
                        restore_pc <= pc_table[next_idx];
                    end
                end
                RESTORE: slice_cnt <= '0;
                default: ;
            endcase
        end
    end

`ifdef SCHED_STATS_EN
    logic [15:0] stat_cnt [NUM_PROCS];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_PROCS; i++)
                stat_cnt[i] <= '0;
        end else if (state == RESTORE && stat_cnt[exec_proc] != 16'hFFFF) begin
            stat_cnt[exec_proc] <= stat_cnt[exec_proc] + 16'd1;
        end
    end

    assign stat_count = stat_cnt[stat_sel];
`else
    logic unused_stat_sel;

    assign unused_stat_sel = ^stat_sel;
    assign stat_count      = '0;
`endif

endmodule

// File: tb/tb_proc_scheduler.sv
// Self-checking bench for proc_scheduler: directed scenarios plus randomized traffic against a behavioural model.
module tb_proc_scheduler;

    localparam int NP = 4;
    localparam int PW = 10;
    localparam int QW = 16;
    localparam int IW = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable, quantum_wr, retire, yield, swap_ack;
    logic [QW-1:0] quantum_in;
    logic [NP-1:0] proc_ready;
    logic [PW-1:0] cur_pc;
    logic          swap_req, change_proc_pc, idle;
    logic [PW-1:0] restore_pc;
    logic [IW-1:0] exec_proc, stat_sel;
    logic [15:0]   stat_count;

    int checks = 0;
    int errors = 0;

    // Model: running slot, slice count, quantum, saved PCs, swap-in counts, swap progress
    // m_step: 0 running, 1 awaiting ack, 2 saving, 3 picking, 4 restoring, 5 idle
    int m_exec, m_cnt, m_quantum, m_rpc, m_step;
    int m_pc   [NP];
    int m_stat [NP];

    int ack_slow = 0;
    bit pc_hold  = 0;

    always #5 clock = ~clock;

    proc_scheduler #(
        .NUM_PROCS  (NP),
        .PC_W       (PW),
        .QUANTUM_W  (QW),
        .DEF_QUANTUM(100)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .quantum_wr    (quantum_wr),
        .quantum_in    (quantum_in),
        .proc_ready    (proc_ready),
        .retire        (retire),
        .yield         (yield),
        .cur_pc        (cur_pc),
        .swap_ack      (swap_ack),
        .swap_req      (swap_req),
        .change_proc_pc(change_proc_pc),
        .restore_pc    (restore_pc),
        .exec_proc     (exec_proc),
        .idle          (idle),
        .stat_sel      (stat_sel),
        .stat_count    (stat_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_exec = 0; m_cnt = 0; m_quantum = 100; m_rpc = 0; m_step = 0;
        for (int i = 0; i < NP; i++) begin
            m_pc[i]   = i * ((1 << PW) / NP);
            m_stat[i] = 0;
        end
    endtask

    task automatic compare();
        check("swap_req", swap_req, m_step == 1);
        check("change_proc_pc", change_proc_pc, m_step == 4);
        check("idle", idle, m_step == 5);
        check("exec_proc", exec_proc, m_exec);
        check("restore_pc", restore_pc, m_rpc);
`ifdef SCHED_STATS_EN
        check("stat_count", stat_count, m_stat[stat_sel]);
`else
        check("stat_count", stat_count, 0);
`endif
    endtask

    task automatic advance();
        int  nq;
        bit  go;
        bit  found;
        int  j;
        nq = quantum_wr ? ((quantum_in == 0) ? 1 : int'(quantum_in)) : m_quantum;
        case (m_step)
            0: if (enable) begin
                go = yield || !proc_ready[m_exec] || (retire && (m_cnt + 1 >= m_quantum));
                if (retire) m_cnt++;
                if (go) m_step = 1;
            end
            1: if (swap_ack) m_step = 2;
            2: begin
                m_pc[m_exec] = int'(cur_pc);
                m_step = 3;
            end
            3: begin
                found = 0;
                for (int k = 1; k <= NP; k++) begin
                    j = (m_exec + k) % NP;
                    if (!found && proc_ready[j]) begin
                        found = 1;
                        m_exec = j;
                    end
                end
                if (found) begin
                    m_rpc  = m_pc[m_exec];
                    m_step = 4;
                end else begin
                    m_step = 5;
                end
            end
            4: begin
                m_cnt = 0;
                if (m_stat[m_exec] < 65535) m_stat[m_exec]++;
                m_step = 0;
            end
            5: if (proc_ready != 0) m_step = 3;
            default: ;
        endcase
        m_quantum = nq;
    endtask

    task automatic cyc(input bit en, input bit ret, input bit yld, input logic [NP-1:0] rdy,
                       input bit qwr = 0, input int qin = 0);
        @(negedge clock);
        enable     = en;
        retire     = ret;
        yield      = yld;
        proc_ready = rdy;
        quantum_wr = qwr;
        quantum_in = QW'(qin);
        swap_ack   = (m_step == 1) && ($urandom_range(0, ack_slow) == 0);
        if (m_step == 0 && !pc_hold) cur_pc = PW'($urandom);
        stat_sel   = IW'($urandom);
        #1;
        compare();
        advance();
    endtask

    task automatic quiet_inputs();
        enable = 0; retire = 0; yield = 0; swap_ack = 0; quantum_wr = 0; quantum_in = '0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        quiet_inputs();
        reset = 0;
        #1;
        model_reset();
        compare();
        @(negedge clock);
        reset = 1;
        #1;
        compare();
        advance();
    endtask

    task automatic run_until_swap(input string tag, input bit en, input bit ret, input bit yld,
                                  input logic [NP-1:0] rdy, input int limit, output int n);
        n = 0;
        for (int i = 0; i < limit; i++) begin
            cyc(en, ret, yld, rdy);
            n++;
            if (change_proc_pc === 1'b1) break;
        end
        check({tag, "_swap_seen"}, change_proc_pc, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int          n;
        logic [NP-1:0] rdy;
        reset = 0;
        quiet_inputs();
        proc_ready = '0;
        cur_pc     = '0;
        stat_sel   = '0;
        model_reset();

        // 1: quantum 3, two ready slots, immediate ack
        do_reset();
        cyc(1, 0, 0, 4'b0011, 1, 3);
        run_until_swap("t1", 1, 1, 0, 4'b0011, 20, n);
        check("t1_latency", n, 7);
        check("t1_exec", exec_proc, 1);
        check("t1_rpc", restore_pc, 256);
        cyc(1, 1, 0, 4'b0011);
        check("t1_pulse", change_proc_pc, 0);

        // 2: yield with PC 5 saved, then swap back restores it
        do_reset();
        cur_pc = 10'h005;
        pc_hold = 1;
        cyc(1, 0, 1, 4'b1001);
        run_until_swap("t2a", 1, 0, 0, 4'b1001, 10, n);
        check("t2_exec", exec_proc, 3);
        check("t2_rpc", restore_pc, 768);
        cur_pc = 10'h2AB;
        cyc(1, 0, 1, 4'b1001);
        run_until_swap("t2b", 1, 0, 0, 4'b1001, 10, n);
        check("t2_back_exec", exec_proc, 0);
        check("t2_back_rpc", restore_pc, 5);

        // 3: lone ready slot re-selects itself, slice restarts from zero
        do_reset();
        cyc(1, 0, 0, 4'b0001, 1, 2);
        cur_pc = 10'h123;
        run_until_swap("t3a", 1, 1, 0, 4'b0001, 20, n);
        check("t3_exec", exec_proc, 0);
        check("t3_rpc", restore_pc, 10'h123);
        run_until_swap("t3b", 1, 1, 0, 4'b0001, 20, n);
        check("t3_slice_restart", n, 6);
        pc_hold = 0;

        // 4: nothing ready after ack -> idle, then wake on slot 2
        do_reset();
        cyc(1, 0, 1, 4'b0011);
        cyc(1, 0, 0, 4'b0000);
        repeat (3) cyc(1, 0, 0, 4'b0000);
        check("t4_idle", idle, 1);
        run_until_swap("t4", 1, 0, 0, 4'b0100, 10, n);
        check("t4_wake_latency", n, 3);
        check("t4_exec", exec_proc, 2);
        check("t4_idle_clear", idle, 0);

        // 5: quantum 0 behaves as 1; shrinking quantum below count expires on next retire
        do_reset();
        cyc(1, 0, 0, 4'b0011, 1, 0);
        run_until_swap("t5a", 1, 1, 0, 4'b0011, 20, n);
        check("t5_q0_latency", n, 5);
        run_until_swap("t5b", 1, 1, 0, 4'b0011, 20, n);
        check("t5_q0_again", n, 5);
        do_reset();
        cyc(1, 0, 0, 4'b0011, 1, 10);
        repeat (7) cyc(1, 1, 0, 4'b0011);
        cyc(1, 0, 0, 4'b0011, 1, 5);
        cyc(1, 1, 0, 4'b0011);
        cyc(1, 0, 0, 4'b0011);
        check("t5_shrink_req", swap_req, 1);

        // 6: reset during SAVE, saved PC lost; stats into slot 1
        do_reset();
        cyc(1, 0, 1, 4'b0011);
        cyc(1, 0, 0, 4'b0011);
        @(posedge clock);
        #2;
        reset = 0;
        #1;
        model_reset();
        compare();
        check("t6_rst_flags", {swap_req, change_proc_pc, idle}, 0);
        check("t6_rst_exec", exec_proc, 0);
        @(negedge clock);
        quiet_inputs();
        reset = 1;
        #1;
        compare();
        advance();
        cyc(1, 0, 1, 4'b0011);
        run_until_swap("t6a", 1, 0, 0, 4'b0011, 10, n);
        check("t6_rpc_default", restore_pc, 256);
        do_reset();
        repeat (3) run_until_swap("t6s", 1, 0, 1, 4'b0010, 10, n);
        cyc(1, 0, 0, 4'b0010);
        stat_sel = 1;
        #1;
`ifdef SCHED_STATS_EN
        check("t6_stats", stat_count, 3);
`else
        check("t6_stats", stat_count, 0);
`endif

        // Randomized traffic: slow acks, changing ready set, quantum rewrites, enable drops
        ack_slow = 3;
        do_reset();
        rdy = 4'b1111;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) rdy = 4'($urandom);
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0,
                rdy, $urandom_range(0, 49) == 0, int'($urandom_range(0, 6)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
